// File: rtl/link_sync_ctrl.sv
// link_sync_ctrl: comma word alignment and link-state controller for the 8b/10b receive path
module link_sync_ctrl #(
    parameter int HUNT_WORDS   = 20,
    parameter int SLIP_SETTLE  = 4,
    parameter int COMMA_NEEDED = 3,
    parameter int ERR_LIMIT    = 8,
    parameter int GOOD_WINDOW  = 64
) (
    input  logic        byteclk,
    input  logic        rst_n,
    input  logic        sym_valid,
    input  logic        is_comma,
    input  logic        code_err,
    input  logic        disp_err,
    input  logic        force_resync,
    output logic        slip,
    output logic        decoder_rst,
    output logic        link_up,
    output logic [1:0]  state,
    output logic [15:0] err_total,
    output logic [7:0]  lock_loss
);
    localparam int HW = $clog2(HUNT_WORDS + 1);
    localparam int SW = $clog2(SLIP_SETTLE + 1);
    localparam int CW = $clog2(COMMA_NEEDED + 1);
    localparam int LW = $clog2(ERR_LIMIT + 1);
    localparam int GW = $clog2(GOOD_WINDOW + 1);
    localparam logic [HW-1:0] HUNT_LAST   = HW'(HUNT_WORDS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SLIP_SETTLE - 1);
    localparam logic [CW-1:0] COMMA_LAST  = CW'(COMMA_NEEDED - 1);
    localparam logic [LW-1:0] LEAK_LAST   = LW'(ERR_LIMIT - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(GOOD_WINDOW - 1);

    typedef enum logic [1:0] {HUNT = 2'd0, SLIP = 2'd1, VERIFY = 2'd2, LOCKED = 2'd3} state_t;

    state_t        cur, nxt;
    logic [HW-1:0] hunt_cnt;
    logic [SW-1:0] settle_cnt;
    logic [CW-1:0] comma_cnt;
    logic [LW-1:0] leak_cnt;
    logic [GW-1:0] good_cnt;
    logic          err, comma, slip_nxt, decoder_rst_nxt, lost;

    // an erroneous comma is treated purely as an error
    assign err   = sym_valid & (code_err | disp_err);
    assign comma = sym_valid & is_comma & ~err;
    assign state = cur;

    // state register
    always_ff @(posedge byteclk) begin
        if (!rst_n) cur <= HUNT;
        else        cur <= nxt;
    end

    // next state; a resync request overrides every other transition
    always_comb begin
        nxt = cur;
        if (force_resync) nxt = HUNT;
        else begin
            case (cur)
                HUNT:    nxt = comma ? VERIFY : (sym_valid && hunt_cnt == HUNT_LAST) ? SLIP : HUNT;
                SLIP:    nxt = (settle_cnt == SETTLE_LAST) ? HUNT : SLIP;
                VERIFY:  nxt = err ? SLIP : (comma && comma_cnt == COMMA_LAST) ? LOCKED : VERIFY;
                LOCKED:  nxt = (err && leak_cnt == LEAK_LAST) ? HUNT : LOCKED;
                default: nxt = HUNT;
            endcase
        end
    end

    // pulse requests derived from the upcoming transition
    always_comb begin
        slip_nxt        = (nxt == SLIP) && (cur != SLIP);
        decoder_rst_nxt = force_resync || ((cur == LOCKED) && (nxt == HUNT));
        lost            = (cur == LOCKED) && (nxt != LOCKED);
    end

    // registered outputs; link_up tracks LOCKED exactly
    always_ff @(posedge byteclk) begin
        if (!rst_n) begin
            slip        <= 1'b0;
            decoder_rst <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            slip        <= slip_nxt;
            decoder_rst <= decoder_rst_nxt;
            link_up     <= (nxt == LOCKED);
        end
    end

    // window counters, each zero whenever its state is not being occupied
    always_ff @(posedge byteclk) begin
        if (!rst_n || force_resync) begin
            hunt_cnt   <= '0;
            settle_cnt <= '0;
            comma_cnt  <= '0;
            leak_cnt   <= '0;
            good_cnt   <= '0;
        end else begin
            hunt_cnt   <= (cur == HUNT && nxt == HUNT) ? hunt_cnt + HW'(sym_valid) : '0;
            settle_cnt <= (cur == SLIP && nxt == SLIP) ? settle_cnt + SW'(1) : '0;
            comma_cnt  <= (nxt == VERIFY) ? comma_cnt + CW'(comma) : '0;
            leak_cnt   <= (cur != LOCKED || nxt != LOCKED) ? '0 :
                          err ? leak_cnt + LW'(1) :
                          (sym_valid && good_cnt == GOOD_LAST && leak_cnt != '0) ? leak_cnt - LW'(1) : leak_cnt;
            good_cnt   <= (cur != LOCKED || nxt != LOCKED || err) ? '0 :
                          sym_valid ? ((good_cnt == GOOD_LAST) ? '0 : good_cnt + GW'(1)) : good_cnt;
        end
    end

    // saturating statistics, cleared only by reset
    always_ff @(posedge byteclk) begin
        if (!rst_n) begin
            err_total <= '0;
            lock_loss <= '0;
        end else begin
            if (cur == LOCKED && err && err_total != 16'hFFFF) err_total <= err_total + 16'd1;
            if (lost && lock_loss != 8'hFF) lock_loss <= lock_loss + 8'd1;
        end
    end
endmodule

// File: tb/tb_link_sync_ctrl.sv
// tb_link_sync_ctrl: directed stimulus with a cycle-level behavioural model of the link controller
module tb_link_sync_ctrl;
    logic        byteclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sym_valid = 1'b0, is_comma = 1'b0, code_err = 1'b0, disp_err = 1'b0, force_resync = 1'b0;
    logic        slip, decoder_rst, link_up;
    logic [1:0]  state;
    logic [15:0] err_total;
    logic [7:0]  lock_loss;

    int errors = 0, checks = 0;
    bit chk_en = 1'b0;
    int slip_seen = 0, drst_seen = 0;

    int m_st = 0, m_hunt = 0, m_settle = 0, m_commas = 0, m_leak = 0, m_good = 0;
    int m_etot = 0, m_ll = 0, m_leak_peak = 0;
    bit m_slip = 1'b0, m_drst = 1'b0, m_e, m_cm;

    link_sync_ctrl dut (
        .byteclk(byteclk), .rst_n(rst_n), .sym_valid(sym_valid), .is_comma(is_comma),
        .code_err(code_err), .disp_err(disp_err), .force_resync(force_resync),
        .slip(slip), .decoder_rst(decoder_rst), .link_up(link_up), .state(state),
        .err_total(err_total), .lock_loss(lock_loss)
    );

    always #5 byteclk = ~byteclk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: counts symbols the way the link rules describe them (0=HUNT 1=SLIP 2=VERIFY 3=LOCKED)
    always @(posedge byteclk) begin
        m_e = sym_valid && (code_err || disp_err);
        m_cm = sym_valid && is_comma && !m_e;
        m_slip = 1'b0;
        m_drst = 1'b0;
        if (!rst_n) begin
            m_st = 0; m_hunt = 0; m_settle = 0; m_commas = 0; m_leak = 0; m_good = 0;
            m_etot = 0; m_ll = 0;
        end else begin
            if (m_st == 3 && m_e && m_etot < 65535) m_etot++;
            if (force_resync) begin
                if (m_st == 3 && m_ll < 255) m_ll++;
                m_st = 0; m_hunt = 0; m_settle = 0; m_commas = 0; m_leak = 0; m_good = 0;
                m_drst = 1'b1;
            end else if (m_st == 0) begin
                if (m_cm) begin
                    m_st = 2; m_commas = 1;
                end else if (sym_valid) begin
                    m_hunt++;
                    if (m_hunt == 20) begin
                        m_st = 1; m_settle = 0; m_slip = 1'b1; m_hunt = 0;
                    end
                end
            end else if (m_st == 1) begin
                m_settle++;
                if (m_settle == 4) begin
                    m_st = 0; m_settle = 0; m_hunt = 0;
                end
            end else if (m_st == 2) begin
                if (m_e) begin
                    m_st = 1; m_settle = 0; m_slip = 1'b1; m_commas = 0;
                end else if (m_cm) begin
                    m_commas++;
                    if (m_commas == 3) begin
                        m_st = 3; m_commas = 0; m_leak = 0; m_good = 0; m_leak_peak = 0;
                    end
                end
            end else begin
                if (m_e) begin
                    m_leak++;
                    m_good = 0;
                    if (m_leak > m_leak_peak) m_leak_peak = m_leak;
                    if (m_leak == 8) begin
                        m_st = 0; m_drst = 1'b1; m_leak = 0; m_hunt = 0;
                        if (m_ll < 255) m_ll++;
                    end
                end else if (sym_valid) begin
                    m_good++;
                    if (m_good == 64) begin
                        m_good = 0;
                        if (m_leak > 0) m_leak--;
                    end
                end
            end
        end
    end

    // compare every cycle on the falling edge, away from the active edge
    always @(negedge byteclk) begin
        if (chk_en) begin
            check("state", int'(state), m_st);
            check("slip", int'(slip), int'(m_slip));
            check("decoder_rst", int'(decoder_rst), int'(m_drst));
            check("link_up", int'(link_up), int'(m_st == 3));
            check("err_total", int'(err_total), m_etot);
            check("lock_loss", int'(lock_loss), m_ll);
            slip_seen += int'(slip);
            drst_seen += int'(decoder_rst);
        end
    end

    task automatic step(input bit v, input bit c, input bit ce, input bit de, input bit fr);
        @(negedge byteclk);
        sym_valid = v; is_comma = c; code_err = ce; disp_err = de; force_resync = fr;
    endtask

    task automatic idle();      step(0, 0, 0, 0, 0); endtask
    task automatic comma_sym(); step(1, 1, 0, 0, 0); endtask
    task automatic data_sym();  step(1, 0, 0, 0, 0); endtask
    task automatic bad_sym();   step(1, 0, 1, 0, 0); endtask

    task automatic do_reset();
        @(negedge byteclk);
        rst_n = 1'b0; sym_valid = 0; is_comma = 0; code_err = 0; disp_err = 0; force_resync = 0;
        @(negedge byteclk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_slip"}, int'(slip), 0);
        check({tag, "_decoder_rst"}, int'(decoder_rst), 0);
        check({tag, "_link_up"}, int'(link_up), 0);
        check({tag, "_err_total"}, int'(err_total), 0);
        check({tag, "_lock_loss"}, int'(lock_loss), 0);
    endtask

    initial begin
        int s0, d0;
        do_reset();
        check_all_zero("reset");
        chk_en = 1'b1;

        // clean aligned commas
        s0 = slip_seen;
        comma_sym();
        idle();
        check("t1_verify", int'(state), 2);
        comma_sym();
        comma_sym();
        idle();
        check("t1_locked", int'(state), 3);
        check("t1_link_up", int'(link_up), 1);
        check("t1_no_slip", slip_seen - s0, 0);

        // three hunt timeouts, commas offered during settle are ignored
        do_reset();
        s0 = slip_seen;
        for (int r = 0; r < 3; r++) begin
            repeat (20) data_sym();
            if (r == 0) check("t2_hunt_after_19", int'(state), 0);
            comma_sym();
            if (r == 0) begin
                check("t2_slip_state", int'(state), 1);
                check("t2_slip_pulse", int'(slip), 1);
            end
            repeat (3) comma_sym();
        end
        repeat (3) comma_sym();
        idle();
        check("t2_slip_count", slip_seen - s0, 3);
        check("t2_locked", int'(state), 3);

        // eight errors inside one good window drop the link
        d0 = drst_seen;
        repeat (8) begin
            bad_sym();
            data_sym();
            data_sym();
        end
        idle();
        check("t3_link_down", int'(link_up), 0);
        check("t3_hunt", int'(state), 0);
        check("t3_lock_loss", int'(lock_loss), 1);
        check("t3_err_total", int'(err_total), 8);
        check("t3_decoder_rst_once", drst_seen - d0, 1);

        // sparse errors are forgiven by the leaky count
        do_reset();
        repeat (3) comma_sym();
        repeat (100) begin
            bad_sym();
            repeat (70) data_sym();
        end
        idle();
        check("t4_link_up", int'(link_up), 1);
        check("t4_err_total", int'(err_total), 100);
        check("t4_lock_loss", int'(lock_loss), 0);
        check("t4_model_leak_peak", m_leak_peak, 1);

        // bad comma in VERIFY slips; resync during settle returns to HUNT
        step(0, 0, 0, 0, 1);
        comma_sym();
        step(1, 1, 0, 1, 0);
        idle();
        check("t5_slip_state", int'(state), 1);
        check("t5_slip_pulse", int'(slip), 1);
        step(0, 0, 0, 0, 1);
        idle();
        check("t5_hunt", int'(state), 0);
        check("t5_decoder_rst", int'(decoder_rst), 1);
        check("t5_slip_low", int'(slip), 0);
        check("t5_lock_loss", int'(lock_loss), 1);

        // reset while locked, then saturate the lock-loss counter
        do_reset();
        repeat (3) comma_sym();
        repeat (5) bad_sym();
        idle();
        check("t6_err_total_5", int'(err_total), 5);
        check("t6_locked", int'(link_up), 1);
        do_reset();
        check_all_zero("t6_reset");
        repeat (260) begin
            repeat (3) comma_sym();
            repeat (8) bad_sym();
        end
        idle();
        check("t6_lock_loss_sat", int'(lock_loss), 255);
        check("t6_err_total", int'(err_total), 2080);
        check("t6_hunt", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
